nabp_shifter: RTL and testbench
===============================

# nabp_shifter

Line-feed sequencer at the upstream end of the shifter/mapper handshake. It drives `sh_kick`, `sh_shift_en` and `sh_done` to the mapper, which converts each shift into a line-buffer address `fr_s_val`. It captures the line-buffer read data returned for each address into an NUM_PE-deep shift register that feeds the processing-element array. One start request from state control produces exactly one full projection line of shifts.

## Interface
- LINE_SIZE, 256, shifts (projection samples) per line; ≥2
- DATA_WIDTH, 12, width of one line-buffer word
- NUM_PE, 8, shift-register depth (words presented to PEs)

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- sc_start  in  1  start request from state control; sampled only in READY
- pe_stall  in  1  PE array back-pressure; gates issue of new shifts
- fr_data  in  DATA_WIDTH  line-buffer read data, valid one cycle after the cycle its address was presented
- sh_ready  out  1  high in READY
- sh_kick  out  1  one-cycle pulse starting a line (to mapper)
- sh_shift_en  out  1  advance mapper accumulator / issue a read this cycle
- sh_done  out  1  one-cycle pulse ending a line (to mapper)
- sh_data  out  NUM_PE*DATA_WIDTH  shift register; word 0 (LSBs) newest
- sh_data_valid  out  1  sh_data updated with a new word this cycle

## Operation
- States: READY, KICK, SHIFT, DRAIN, DONE.
- READY: sh_ready=1. sc_start=1 → KICK. sc_start is ignored in every other state.
- KICK: sh_kick=1 for one cycle; shift counter cleared to 0 → SHIFT.
- SHIFT: sh_shift_en = !pe_stall.
  - Counter (width clog2(LINE_SIZE)) increments on each cycle with sh_shift_en=1.
  - A shift with counter == LINE_SIZE-1 → DRAIN.
  - While pe_stall=1: stay in SHIFT; counter holds.
- DRAIN: one cycle, no shift; the last read returns → DONE.
- DONE: sh_done=1 for one cycle → READY.
- Capture: shift_en_d = sh_shift_en registered.
  - When shift_en_d=1, sh_data shifts up one word, fr_data enters word 0, and the oldest word is discarded.
  - The capture of an in-flight word is never blocked by pe_stall. Stall gates only new issues.
- sh_data_valid = shift_en_d registered: high in the cycle sh_data first shows the new word.
- Exactly LINE_SIZE issues and LINE_SIZE captures per line.
- sh_data is not cleared between lines. Words from the previous line persist until shifted out.
- Reset (any state, including mid-line): state=READY, counter=0, shift_en_d=0, sh_data=0. Outputs after reset: sh_ready=1, all other outputs 0. An in-flight read is discarded.

## Timing
- Cycle n is the cycle sc_start is sampled high in READY. Cycle numbers below assume no stall.
- Cycle n+1: sh_kick=1, sh_ready=0.
- Cycles n+2 … n+LINE_SIZE+1: sh_shift_en=1.
- Cycle n+LINE_SIZE+2: DRAIN.
- Cycle n+LINE_SIZE+3: sh_done=1.
- Cycle n+LINE_SIZE+4: sh_ready=1. The earliest next sc_start is sampled here.
- Issue→data: the address is presented at cycle t, fr_data is captured at the end of t+1, and sh_data/sh_data_valid update at t+2.
- First sh_data_valid at n+4. The last sh_data_valid coincides with sh_done.
- Each stall cycle in SHIFT extends the whole sequence by one cycle.
- pe_stall in READY, KICK, DRAIN or DONE has no effect.
- All outputs are registered or decoded from registered state. No combinational path from inputs to outputs except pe_stall → sh_shift_en.

## Test plan
- LINE_SIZE=8, NUM_PE=4, fr_data model returns issue index k+1 one cycle after issue k; sc_start at cycle 0:
  - sh_kick at cycle 1.
  - sh_shift_en at cycles 2–9.
  - sh_done at cycle 11.
  - Final sh_data words 0–3 = 8,7,6,5.
  - Exactly 8 sh_data_valid pulses.
- Same setup with pe_stall=1 at cycles 4–6:
  - sh_shift_en low at cycles 4–6; 8 issues total.
  - sh_done at cycle 14.
  - Sequence captured in order with no duplicates.
  - The word issued at cycle 3 is still captured at the end of cycle 4.
- sc_start held high continuously:
  - Back-to-back lines with sh_done at cycle 11 and the next sh_kick at cycle 13.
  - No second kick in cycles 2–11.
- reset_n=0 at cycle 6 mid-SHIFT:
  - From the following cycle: sh_ready=1, sh_data=0, no sh_done.
  - A later sc_start yields a full, clean 8-shift line.
- LINE_SIZE=2, sc_start at cycle 0:
  - sh_shift_en at cycles 2–3.
  - sh_done at cycle 5.
  - sh_data word 0 = 2, word 1 = 1.
  - pe_stall held high throughout KICK extends nothing.

Source files
------------

// File: rtl/nabp_shifter.sv
// Line-feed sequencer: issues one projection line of shifts to the mapper and
// collects the returned line-buffer words into an NUM_PE-deep shift register.
module nabp_shifter #(
  parameter int LINE_SIZE  = 256,
  parameter int DATA_WIDTH = 12,
  parameter int NUM_PE     = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         sc_start,
  input  logic                         pe_stall,
  input  logic [DATA_WIDTH-1:0]        fr_data,
  output logic                         sh_ready,
  output logic                         sh_kick,
  output logic                         sh_shift_en,
  output logic                         sh_done,
  output logic [NUM_PE*DATA_WIDTH-1:0] sh_data,
  output logic                         sh_data_valid
);

  localparam int CNT_W = (LINE_SIZE > 1) ? $clog2(LINE_SIZE) : 1;
  localparam int SH_W  = NUM_PE * DATA_WIDTH;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_SIZE - 1);

  typedef enum logic [2:0] {
    READY = 3'd0,
    KICK  = 3'd1,
    SHIFT = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              vld_p1_q, vld_p1_d;
  logic              vld_p2_q, vld_p2_d;
  logic [SH_W-1:0]   sh_data_q, sh_data_d;
  logic              shift_en;

  // Stage p0: sequencing and shift issue
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_en = 1'b0;
    case (state_q)
      READY: if (sc_start) state_d = KICK;
      KICK: begin
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        shift_en = !pe_stall;
        if (shift_en) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) state_d = DRAIN;
        end
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = READY;
      default: state_d = READY;
    endcase
  end

  // Stage p1: the read issued last cycle returns; capture is never stalled
  always_comb begin
    vld_p1_d  = shift_en;
    vld_p2_d  = vld_p1_q;
    sh_data_d = sh_data_q;
    if (vld_p1_q) sh_data_d = (sh_data_q << DATA_WIDTH) | SH_W'(fr_data);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= READY;
      cnt_q     <= '0;
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      sh_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      vld_p1_q  <= vld_p1_d;
      vld_p2_q  <= vld_p2_d;
      sh_data_q <= sh_data_d;
    end
  end

  // Stage p2: registered/decoded outputs
  assign sh_ready      = (state_q == READY);
  assign sh_kick       = (state_q == KICK);
  assign sh_done       = (state_q == DONE);
  assign sh_shift_en   = shift_en;
  assign sh_data       = sh_data_q;
  assign sh_data_valid = vld_p2_q;

endmodule

// File: tb/tb_nabp_shifter.sv
// Directed bench for nabp_shifter: an 8-sample line with 4 PEs and a
// 2-sample line, with a line-buffer model returning issue index + 1.
module tb_nabp_shifter;
  localparam int DW  = 12;
  localparam int NPE = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, sc_start, pe_stall, sel;
  logic [DW-1:0] fr_data;

  logic a_rdy, a_kick, a_sen, a_done, a_vld;
  logic b_rdy, b_kick, b_sen, b_done, b_vld;
  logic [NPE*DW-1:0] a_data, b_data;
  logic sc_a, sc_b;

  assign sc_a = sc_start & ~sel;
  assign sc_b = sc_start & sel;

  nabp_shifter #(.LINE_SIZE(8), .DATA_WIDTH(DW), .NUM_PE(NPE)) u_l8 (
    .clk(clk), .reset_n(reset_n), .sc_start(sc_a), .pe_stall(pe_stall),
    .fr_data(fr_data), .sh_ready(a_rdy), .sh_kick(a_kick),
    .sh_shift_en(a_sen), .sh_done(a_done), .sh_data(a_data),
    .sh_data_valid(a_vld));

  nabp_shifter #(.LINE_SIZE(2), .DATA_WIDTH(DW), .NUM_PE(NPE)) u_l2 (
    .clk(clk), .reset_n(reset_n), .sc_start(sc_b), .pe_stall(pe_stall),
    .fr_data(fr_data), .sh_ready(b_rdy), .sh_kick(b_kick),
    .sh_shift_en(b_sen), .sh_done(b_done), .sh_data(b_data),
    .sh_data_valid(b_vld));

  logic o_rdy, o_kick, o_sen, o_done, o_vld;
  logic [NPE*DW-1:0] o_data;
  assign o_rdy  = sel ? b_rdy  : a_rdy;
  assign o_kick = sel ? b_kick : a_kick;
  assign o_sen  = sel ? b_sen  : a_sen;
  assign o_done = sel ? b_done : a_done;
  assign o_vld  = sel ? b_vld  : a_vld;
  assign o_data = sel ? b_data : a_data;

  int nchecks = 0;
  int nerr    = 0;
  int cyc, k, nvld;
  logic [63:0] kick_h, sen_h, done_h, vld_h, rdy_h;
  logic [DW-1:0] cap[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic begin_line();
    cyc = 0; k = 0; nvld = 0;
    kick_h = '0; sen_h = '0; done_h = '0; vld_h = '0; rdy_h = '0;
    cap.delete();
  endtask

  // One clock cycle: apply inputs, record outputs, advance; line-buffer model
  // answers issue k with k+1 in the cycle after the issue.
  task automatic step(input logic start, input logic stall);
    logic issue;
    sc_start = start;
    pe_stall = stall;
    #1;
    if (cyc < 64) begin
      kick_h[cyc] = o_kick; sen_h[cyc] = o_sen; done_h[cyc] = o_done;
      vld_h[cyc]  = o_vld;  rdy_h[cyc] = o_rdy;
    end
    if (o_vld) begin
      nvld++;
      cap.push_back(o_data[DW-1:0]);
    end
    issue = o_sen;
    @(posedge clk);
    #1;
    if (issue) begin
      k++;
      fr_data = DW'(k);
    end
    cyc++;
  endtask

  task automatic chk_seq(input string tag, input int n);
    chk({tag, "_count"}, 64'(cap.size()), 64'(n));
    for (int i = 0; i < n && i < cap.size(); i++)
      chk({tag, "_word"}, 64'(cap[i]), 64'(i + 1));
  endtask

  initial begin
    reset_n = 1'b0; sc_start = 1'b0; pe_stall = 1'b0; sel = 1'b0; fr_data = '0;
    @(posedge clk); #1;
    begin_line();
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    chk("rst_ready", 64'(o_rdy), 64'd1);
    chk("rst_others", {o_kick, o_sen, o_done, o_vld}, 64'd0);
    chk("rst_data", 64'(o_data), 64'd0);
    reset_n = 1'b1;
    step(1'b0, 1'b0);

    // Unstalled 8-sample line
    begin_line();
    step(1'b1, 1'b0);
    repeat (13) step(1'b0, 1'b0);
    chk("l8_kick", kick_h & 64'h3FFF, 64'h0002);
    chk("l8_shift_en", sen_h & 64'h3FFF, 64'h03FC);
    chk("l8_done", done_h & 64'h3FFF, 64'h0800);
    chk("l8_valid", vld_h & 64'h3FFF, 64'h0FF0);
    chk("l8_ready", rdy_h & 64'h3FFF, 64'h3001);
    chk("l8_nvalid", 64'(nvld), 64'd8);
    chk("l8_data", 64'(o_data), 64'h005006007008);
    chk_seq("l8_seq", 8);

    // Stall at cycles 4-6
    begin_line();
    step(1'b1, 1'b0);
    for (int c = 1; c < 17; c++) step(1'b0, (c >= 4 && c <= 6));
    chk("stall_shift_en", sen_h & 64'h1FFFF, 64'h01F8C);
    chk("stall_done", done_h & 64'h1FFFF, 64'h04000);
    chk("stall_valid", vld_h & 64'h1FFFF, 64'h07E30);
    chk("stall_nissue", 64'(k), 64'd8);
    chk("stall_data", 64'(o_data), 64'h005006007008);
    chk_seq("stall_seq", 8);

    // sc_start held high: back-to-back lines
    begin_line();
    repeat (15) step(1'b1, 1'b0);
    repeat (12) step(1'b0, 1'b0);
    chk("b2b_kick", kick_h & 64'h7FFFFFF, 64'h0002002);
    chk("b2b_done", done_h & 64'h7FFFFFF, 64'h0800800);
    chk("b2b_nvalid", 64'(nvld), 64'd16);

    // Reset in the middle of SHIFT
    begin_line();
    step(1'b1, 1'b0);
    repeat (5) step(1'b0, 1'b0);
    reset_n = 1'b0;
    step(1'b0, 1'b0);
    reset_n = 1'b1;
    chk("midrst_ready", 64'(o_rdy), 64'd1);
    chk("midrst_data", 64'(o_data), 64'd0);
    repeat (10) step(1'b0, 1'b0);
    chk("midrst_quiet", (kick_h | sen_h | done_h | vld_h) & 64'h1FF80, 64'd0);
    begin_line();
    step(1'b1, 1'b0);
    repeat (13) step(1'b0, 1'b0);
    chk("postrst_done", done_h & 64'h3FFF, 64'h0800);
    chk("postrst_data", 64'(o_data), 64'h005006007008);
    chk_seq("postrst_seq", 8);

    // 2-sample line, stall high through READY and KICK
    sel = 1'b1;
    step(1'b0, 1'b0);
    begin_line();
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    repeat (6) step(1'b0, 1'b0);
    chk("l2_kick", kick_h & 64'hFF, 64'h02);
    chk("l2_shift_en", sen_h & 64'hFF, 64'h0C);
    chk("l2_done", done_h & 64'hFF, 64'h20);
    chk("l2_ready", rdy_h & 64'hFF, 64'hC1);
    chk("l2_data", 64'(o_data), 64'h000000001002);
    chk_seq("l2_seq", 2);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
